// File: rtl/lbmem_line.sv
// lbmem_line: parametrised line-buffer FIFO with a fill/drain line controller.
// Optional build macro LBMEM_LINE_ERR_EN enables the sticky misuse flag on err.
module lbmem_line #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int LWIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       wen,
    output logic                       full,
    output logic [WIDTH-1:0]           rdata,
    input  logic                       ren,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       line_ready,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LW = (AW+1)'(LWIDTH);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] waddr;
    logic [AW:0] raddr;
    logic [AW:0] waddr_n;
    logic [AW:0] raddr_n;
    logic [AW:0] count_n;
    logic        wr_ok;
    logic        rd_ok;
    logic [0:0]  state;
    logic [0:0]  state_n;

    // Flags are derived from the current pointers only (no lookahead).
    assign empty = (waddr == raddr);
    assign full  = (waddr[AW-1:0] == raddr[AW-1:0]) &&
                   (waddr[AW] != raddr[AW]);
    assign count = waddr - raddr;

    assign wr_ok   = wen && !full;
    assign rd_ok   = ren && !empty;
    assign waddr_n = waddr + (AW+1)'(wr_ok);
    assign raddr_n = raddr + (AW+1)'(rd_ok);
    assign count_n = waddr_n - raddr_n;

    // Pointer registers; reset discards all buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr <= '0;
            raddr <= '0;
        end else begin
            waddr <= waddr_n;
            raddr <= raddr_n;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Registered read port; holds its value unless a read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_ok) begin
            rdata <= mem[raddr[AW-1:0]];
        end
    end

    // Next-state logic for the fill/drain controller, using next-cycle count.
    always_comb begin
        state_n = state;
        unique case (state)
            FILL: begin
                if (count_n >= LW) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (count_n == '0) begin
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // Fill/drain state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    assign line_ready = (state == DRAIN);

`ifdef LBMEM_LINE_ERR_EN
    logic err_q;

    // Sticky misuse flag: write at full or read at empty, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((wen && full) || (ren && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
